// File: rtl/scan_addr_gen.sv
// Scan sequencer driving the select code and enables of a 3-to-8 decoder.
// Define SCAN_BLANK_EN to blank G2B for the first BLANK_CYC cycles of each dwell.
module scan_addr_gen #(
  parameter int CLK_DIV   = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic [2:0] last,
  output logic       C,
  output logic       B,
  output logic       A,
  output logic       G,
  output logic       G2A,
  output logic       G2B,
  output logic       busy,
  output logic       wrap
);

  localparam logic [0:0]  IDLE   = 1'b0;
  localparam logic [0:0]  RUN    = 1'b1;
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  logic [0:0]  state, state_n;
  logic [2:0]  addr, addr_n;
  logic [15:0] pre, pre_n;
  logic        wrap_n, g2b_n;

  always_comb begin
    state_n = state;
    addr_n  = addr;
    pre_n   = pre;
    wrap_n  = 1'b0;
    if (stop) begin
      state_n = IDLE;
      pre_n   = '0;
    end else if (start) begin
      state_n = RUN;
      pre_n   = '0;
      addr_n  = dir ? last : 3'd0;
    end else if (state == RUN) begin
      if (pre == DIV_M1) begin
        pre_n = '0;
        if (!dir) begin
          if (addr >= last) begin
            addr_n = 3'd0;
            wrap_n = 1'b1;
          end else begin
            addr_n = addr + 3'd1;
          end
        end else begin
          // an address left above a shrunken range snaps to the new top without wrapping
          if (addr == 3'd0) begin
            addr_n = last;
            wrap_n = 1'b1;
          end else if (addr > last) begin
            addr_n = last;
          end else begin
            addr_n = addr - 3'd1;
          end
        end
      end else begin
        pre_n = pre + 16'd1;
      end
    end
  end

`ifdef SCAN_BLANK_EN
  always_comb g2b_n = (state_n != RUN) || (pre_n < 16'(BLANK_CYC));
`else
  always_comb g2b_n = (state_n != RUN);
`endif

  // enables are registered from next-state so they change with the address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= 3'd0;
      pre   <= '0;
      wrap  <= 1'b0;
      G     <= 1'b0;
      G2A   <= 1'b1;
      G2B   <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      pre   <= pre_n;
      wrap  <= wrap_n;
      G     <= (state_n == RUN);
      G2A   <= (state_n != RUN);
      G2B   <= g2b_n;
      busy  <= (state_n == RUN);
    end
  end

  assign {C, B, A} = addr;

endmodule

// File: doc/scan_addr_gen.md
Name: scan_addr_gen

Overview:
- Upstream sequencer for the 3-to-8 line decoder stage.
- Generates the select code {C,B,A} and the three enables G, G2A, G2B, so the decoder walks its eight outputs at a fixed scan rate.
- Used for LED chasers and multiplexed 7-segment digit scanning.
- Start/stop control and a one-cycle wrap pulse allow a downstream frame counter to track complete scans.

Parameters:
CLK_DIV, 4, clock cycles per scan step; legal range 1..65535.
BLANK_CYC, 1, blanking cycles per step; used only when SCAN_BLANK_EN is defined; legal range 1..CLK_DIV-1.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse; begins scanning.
stop  input  1  single-cycle pulse; ends scanning.
dir  input  1  0 = count up, 1 = count down; sampled at each step.
last  input  3  highest index scanned; range 0..last.
C  output  1  select MSB.
B  output  1  select mid bit.
A  output  1  select LSB.
G  output  1  decoder enable, active-high.
G2A  output  1  decoder enable, active-low.
G2B  output  1  decoder enable, active-low.
busy  output  1  high while in RUN.
wrap  output  1  one-cycle pulse when the address wraps.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n. Every output is registered.
- Reset values: {C,B,A}=0, G=0, G2A=1, G2B=1, busy=0, wrap=0, prescaler=0, state=IDLE.
- States:
  - IDLE: decoder disabled (G=0, G2A=1, G2B=1). Address holds its last value.
  - RUN: decoder enabled (G=1, G2A=0, G2B=0).
- IDLE to RUN:
  - start=1 causes the transition on the next edge.
  - Address loads 0 if dir=0, or last if dir=1.
  - Prescaler clears to 0. busy=1 and the enables assert in the same cycle.
- RUN to IDLE:
  - stop=1 causes the transition on the next edge.
  - busy=0, enables deassert, address holds, prescaler clears.
- Simultaneous start and stop: stop wins. The block goes to or stays in IDLE.
- start while already in RUN: restarts the scan. Address reloads and prescaler clears, identical to the IDLE entry.
- Prescaler:
  - Counts 0..CLK_DIV-1 while in RUN.
  - When it reaches CLK_DIV-1, the next edge sets it to 0 and steps the address.
  - Each address is therefore held exactly CLK_DIV cycles. CLK_DIV=1 steps every cycle.
- Step, up (dir=0): if addr >= last, addr becomes 0 and wrap=1 for that cycle; otherwise addr+1.
- Step, down (dir=1):
  - addr=0: addr becomes last, wrap=1.
  - addr > last: addr becomes last, no wrap.
  - otherwise: addr-1.
- last=0: addr stays at 0 and wrap pulses every step.
- A change of dir or last takes effect at the next step; the current dwell is never shortened.
- wrap is high only in the cycle in which the wrapped address first appears. It is never high in IDLE.
- Asynchronous reset mid-RUN: all outputs return to their reset values immediately, with no wait for clk.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined:
  - G2B=1 during the first BLANK_CYC cycles of every dwell, i.e. prescaler < BLANK_CYC, to suppress ghosting on multiplexed displays.
  - This includes the first dwell after start.
  - G and G2A are unchanged. Address timing is unchanged.
- Undefined: G2B=0 for the whole of RUN. BLANK_CYC is ignored.

Test Plan:
- Reset then idle: rst_n=0, then release with no start -> {C,B,A}=0, G=0, G2A=1, G2B=1, busy=0 for 20 cycles.
- Up scan: CLK_DIV=4, last=7, dir=0, start pulse.
  - Address sequence 0,1,...,7,0, each held 4 cycles.
  - wrap=1 for one cycle on the return to 0, 32 cycles after RUN entry.
  - G=1, G2A=0, G2B=0 throughout.
- Down scan with reduced range: last=5, dir=1, start -> sequence 5,4,3,2,1,0,5, with wrap on the second 5.
- Shrink last mid-run: up scan, at addr=6 set last=3 -> next step gives 0 with wrap=1.
- Stop and start priority:
  - stop mid-run at addr=3 -> IDLE next edge, busy=0, enables off, addr holds at 3.
  - start and stop in the same cycle -> remains IDLE.
- Async reset and blanking:
  - rst_n pulsed low mid-cycle during RUN -> outputs reach reset values before the next clk edge.
  - With SCAN_BLANK_EN and BLANK_CYC=1 -> G2B=1 in the first cycle of every 4-cycle dwell.
